// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit and a variable-latency data memory.
// The unit drives the request side; the memory returns a one-cycle ack with read data.
interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    output be,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    input  be,
    output ack,
    output rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues byte/half/word accesses over a req/ack bus,
// stalls the pipeline while an access is outstanding and extends load data.
module mem_access_unit (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read_in,
  input  logic               mem_write_in,
  input  logic [1:0]         mem_size_in,
  input  logic               mem_unsigned_in,
  input  logic [31:0]        addr_in,
  input  logic [31:0]        store_data_in,
  output logic [31:0]        load_data_out,
  output logic               stall_out,
  output logic               err_out,
  mem_access_unit_if.master  dmem
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t      state_r;
  state_t      nextState_s;
  logic        access_s;
  logic        aligned_s;
  logic        legal_s;
  logic [1:0]  size_r;
  logic        zeroExt_r;
  logic [1:0]  offset_r;

  // Replicate the right-aligned store operand into every lane it may land in.
  function automatic logic [31:0] formatWdata(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] result;
    case (size)
      2'b00:   result = {4{data[7:0]}};
      2'b01:   result = {2{data[15:0]}};
      default: result = data;
    endcase
    return result;
  endfunction

  function automatic logic [3:0] formatBe(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] result;
    case (size)
      2'b00:   result = 4'b0001 << offset;
      2'b01:   result = offset[1] ? 4'b1100 : 4'b0011;
      default: result = 4'b1111;
    endcase
    return result;
  endfunction

  function automatic logic [31:0] formatLoad(input logic [31:0] word, input logic [1:0] size,
                                              input logic zeroExt, input logic [1:0] offset);
    logic [7:0]  laneByte;
    logic [15:0] laneHalf;
    logic [31:0] result;
    laneByte = word[{offset, 3'b000} +: 8];
    laneHalf = offset[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   result = zeroExt ? {24'h000000, laneByte} : {{24{laneByte[7]}}, laneByte};
      2'b01:   result = zeroExt ? {16'h0000, laneHalf} : {{16{laneHalf[15]}}, laneHalf};
      default: result = word;
    endcase
    return result;
  endfunction

  // Access legality: exactly one of read/write, naturally aligned for its size.
  always_comb begin
    access_s  = mem_read_in | mem_write_in;
    aligned_s = 1'b1;
    case (mem_size_in)
      2'b00:   aligned_s = 1'b1;
      2'b01:   aligned_s = ~addr_in[0];
      default: aligned_s = (addr_in[1:0] == 2'b00);
    endcase
    legal_s = access_s & ~(mem_read_in & mem_write_in) & aligned_s;
  end

  // Stall and error flags; inputs are only meaningful while IDLE.
  always_comb begin
    stall_out = 1'b0;
    err_out   = 1'b0;
    if (state_r == IDLE) begin
      stall_out = legal_s;
      err_out   = access_s & ~legal_s;
    end else if (state_r == BUSY) begin
      stall_out = 1'b1;
    end else begin
      stall_out = 1'b0;
    end
  end

  // Next-state logic; DONE always returns to IDLE so the held instruction is not reissued.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (legal_s) begin
          nextState_s = BUSY;
        end else begin
          nextState_s = IDLE;
        end
      end
      BUSY: begin
        if (dmem.ack) begin
          nextState_s = DONE;
        end else begin
          nextState_s = BUSY;
        end
      end
      DONE:    nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // State register, latched access attributes, bus outputs and load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      size_r        <= 2'b00;
      zeroExt_r     <= 1'b0;
      offset_r      <= 2'b00;
      dmem.req      <= 1'b0;
      dmem.we       <= 1'b0;
      dmem.addr     <= 32'h0000_0000;
      dmem.wdata    <= 32'h0000_0000;
      dmem.be       <= 4'b0000;
      load_data_out <= 32'h0000_0000;
    end else begin
      state_r <= nextState_s;
      case (state_r)
        IDLE: begin
          if (legal_s) begin
            size_r     <= mem_size_in;
            zeroExt_r  <= mem_unsigned_in;
            offset_r   <= addr_in[1:0];
            dmem.req   <= 1'b1;
            dmem.we    <= mem_write_in;
            dmem.addr  <= {addr_in[31:2], 2'b00};
            dmem.wdata <= formatWdata(mem_size_in, store_data_in);
            dmem.be    <= formatBe(mem_size_in, addr_in[1:0]);
          end
        end
        BUSY: begin
          if (dmem.ack) begin
            dmem.req <= 1'b0;
            if (!dmem.we) begin
              load_data_out <= formatLoad(dmem.rdata, size_r, zeroExt_r, offset_r);
            end
          end
        end
        DONE: begin
          dmem.req <= 1'b0;
        end
        default: begin
          dmem.req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expectations are queued when an access is
// driven and retired in the DONE cycle; a bench-side responder supplies the acks.
module tb_mem_access_unit;
  logic        clk;
  logic        rst;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [1:0]  mem_size_in;
  logic        mem_unsigned_in;
  logic [31:0] addr_in;
  logic [31:0] store_data_in;
  logic [31:0] load_data_out;
  logic        stall_out;
  logic        err_out;
  int          checks;
  int          errors;
  int          reqCount;
  logic        reqSeen;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] load;
    int          stalls;
  } scoreItem_t;

  scoreItem_t sbQ[$];

  mem_access_unit_if dmemBus();

  mem_access_unit dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read_in     (mem_read_in),
    .mem_write_in    (mem_write_in),
    .mem_size_in     (mem_size_in),
    .mem_unsigned_in (mem_unsigned_in),
    .addr_in         (addr_in),
    .store_data_in   (store_data_in),
    .load_data_out   (load_data_out),
    .stall_out       (stall_out),
    .err_out         (err_out),
    .dmem            (dmemBus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges of the request line.
  always @(negedge clk) begin
    if (rst) begin
      reqSeen = 1'b0;
    end else begin
      if (dmemBus.req && !reqSeen) reqCount++;
      reqSeen = dmemBus.req;
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clearInputs();
    mem_read_in     = 1'b0;
    mem_write_in    = 1'b0;
    mem_size_in     = 2'b00;
    mem_unsigned_in = 1'b0;
    addr_in         = 32'h0000_0000;
    store_data_in   = 32'h0000_0000;
  endtask

  // Entered and left on a falling edge; returns in the IDLE cycle after DONE.
  task automatic runAccess(input logic rd, input logic wr, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [31:0] rdata, input int waits, input logic [3:0] expBe,
                           input logic [31:0] expWdata, input logic [31:0] expLoad);
    scoreItem_t item;
    int stalls;
    item.we     = wr;
    item.addr   = {addr[31:2], 2'b00};
    item.be     = expBe;
    item.wdata  = expWdata;
    item.load   = expLoad;
    item.stalls = 2 + waits;
    sbQ.push_back(item);
    mem_read_in     = rd;
    mem_write_in    = wr;
    mem_size_in     = size;
    mem_unsigned_in = uns;
    addr_in         = addr;
    store_data_in   = sdata;
    #1;
    stalls = 0;
    if (stall_out) stalls++;
    checkVal("errLegal", 32'(err_out), 32'd0);
    @(negedge clk);
    item = sbQ[0];
    checkVal("busWe", 32'(dmemBus.we), 32'(item.we));
    if (item.we) begin
      checkVal("busBe", 32'(dmemBus.be), 32'(item.be));
      checkVal("busWdata", dmemBus.wdata, item.wdata);
    end
    for (int i = 0; i <= waits; i++) begin
      if (stall_out) stalls++;
      checkVal("busReq", 32'(dmemBus.req), 32'd1);
      checkVal("busAddr", dmemBus.addr, item.addr);
      if (i == waits) begin
        dmemBus.ack   = 1'b1;
        dmemBus.rdata = rdata;
      end
      @(negedge clk);
      dmemBus.ack   = 1'b0;
      dmemBus.rdata = 32'h0000_0000;
    end
    item = sbQ.pop_front();
    if (stall_out) stalls++;
    checkVal("stallDone", 32'(stall_out), 32'd0);
    checkVal("reqDone", 32'(dmemBus.req), 32'd0);
    checkVal("loadData", load_data_out, item.load);
    checkVal("stallCycles", 32'(stalls), 32'(item.stalls));
    @(negedge clk);
  endtask

  // Illegal access: flagged at once, never requested, never stalls.
  task automatic runIllegal(input string tag, input logic rd, input logic wr,
                            input logic [1:0] size, input logic [31:0] addr);
    int reqBefore;
    reqBefore       = reqCount;
    mem_read_in     = rd;
    mem_write_in    = wr;
    mem_size_in     = size;
    addr_in         = addr;
    store_data_in   = 32'h1234_5678;
    #1;
    checkVal({tag, "Err"}, 32'(err_out), 32'd1);
    checkVal({tag, "Stall"}, 32'(stall_out), 32'd0);
    @(negedge clk);
    checkVal({tag, "Req"}, 32'(dmemBus.req), 32'd0);
    checkVal({tag, "ReqCount"}, 32'(reqCount - reqBefore), 32'd0);
    clearInputs();
  endtask

  task automatic checkResetState(input string tag);
    checkVal({tag, "Load"}, load_data_out, 32'h0000_0000);
    checkVal({tag, "Req"}, 32'(dmemBus.req), 32'd0);
    checkVal({tag, "We"}, 32'(dmemBus.we), 32'd0);
    checkVal({tag, "Addr"}, dmemBus.addr, 32'h0000_0000);
    checkVal({tag, "Wdata"}, dmemBus.wdata, 32'h0000_0000);
    checkVal({tag, "Be"}, 32'(dmemBus.be), 32'd0);
    checkVal({tag, "Err"}, 32'(err_out), 32'd0);
    checkVal({tag, "Stall"}, 32'(stall_out), 32'd0);
  endtask

  initial begin
    int reqBefore;
    checks        = 0;
    errors        = 0;
    reqCount      = 0;
    reqSeen       = 1'b0;
    rst           = 1'b1;
    dmemBus.ack   = 1'b0;
    dmemBus.rdata = 32'h0000_0000;
    clearInputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetState("rst");
    rst = 1'b0;
    @(negedge clk);

    // Loads from the same word with different sizes and extensions.
    runAccess(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0102, 32'h0, 32'h8899_AABB, 0, 4'b0000, 32'h0, 32'hFFFF_FF99);
    runAccess(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 32'h8899_AABB, 0, 4'b0000, 32'h0, 32'h0000_8899);
    runAccess(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 32'h8899_AABB, 1, 4'b0000, 32'h0, 32'hFFFF_8899);
    runAccess(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'h8899_AABB, 0, 4'b0000, 32'h0, 32'h8899_AABB);
    runAccess(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0101, 32'h0, 32'h8899_AABB, 0, 4'b0000, 32'h0, 32'h0000_00AA);
    runAccess(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0108, 32'h0, 32'h7766_5544, 0, 4'b0000, 32'h0, 32'h7766_5544);

    // Stores leave load_data_out untouched.
    runAccess(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0203, 32'h0000_00C3, 32'h0, 3, 4'b1000, 32'hC3C3_C3C3, 32'h7766_5544);
    runAccess(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'hABCD_1234, 32'h0, 0, 4'b1100, 32'h1234_1234, 32'h7766_5544);
    runAccess(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0201, 32'h0000_005A, 32'h0, 0, 4'b0010, 32'h5A5A_5A5A, 32'h7766_5544);
    clearInputs();
    @(negedge clk);

    runIllegal("lwMis", 1'b1, 1'b0, 2'b10, 32'h0000_0101);
    runIllegal("shMis", 1'b0, 1'b1, 2'b01, 32'h0000_0001);
    runIllegal("rdWr", 1'b1, 1'b1, 2'b10, 32'h0000_0100);

    // Reset in the second BUSY cycle, then a stray ack while IDLE.
    mem_read_in = 1'b1;
    mem_size_in = 2'b10;
    addr_in     = 32'h0000_0100;
    @(negedge clk);
    checkVal("busyReq1", 32'(dmemBus.req), 32'd1);
    @(negedge clk);
    checkVal("busyStall2", 32'(stall_out), 32'd1);
    rst = 1'b1;
    clearInputs();
    @(negedge clk);
    checkResetState("midRst");
    rst           = 1'b0;
    dmemBus.ack   = 1'b1;
    dmemBus.rdata = 32'hDEAD_DEAD;
    @(negedge clk);
    dmemBus.ack   = 1'b0;
    dmemBus.rdata = 32'h0000_0000;
    checkResetState("strayAck");
    @(negedge clk);

    // Back-to-back LW then SW: exactly two requests, no reissue.
    reqBefore = reqCount;
    runAccess(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'h1122_3344, 0, 4'b0000, 32'h0, 32'h1122_3344);
    runAccess(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0204, 32'hDEAD_BEEF, 32'h0, 0, 4'b1111, 32'hDEAD_BEEF, 32'h1122_3344);
    clearInputs();
    repeat (3) @(negedge clk);
    checkVal("b2bReqCount", 32'(reqCount - reqBefore), 32'd2);
    checkVal("b2bReqIdle", 32'(dmemBus.req), 32'd0);
    checkVal("sbEmpty", 32'(sbQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage data access unit of the five-stage MIPS pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register, and its load_data_out drives MEM/WB's memory-data input. It performs byte, halfword and word loads and stores against a variable-latency data memory through a req/ack handshake. It stalls the upstream pipeline while an access is outstanding and sign- or zero-extends load data.

## Interface
- No parameters; all datapaths are fixed at 32 bits.
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- mem_read_in  in  1  load request from EX/MEM
- mem_write_in  in  1  store request from EX/MEM
- mem_size_in  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word
- mem_unsigned_in  in  1  1 means zero-extend load (LBU/LHU), 0 means sign-extend
- addr_in  in  32  effective byte address (ALU result)
- store_data_in  in  32  store data, right-aligned (rt)
- load_data_out  out  32  formatted load result, registered
- stall_out  out  1  holds PC, IF/ID, ID/EX, EX/MEM and MEM/WB
- err_out  out  1  misaligned or illegal (read and write both set) access
- dmem_req  out  1  memory request, registered
- dmem_we  out  1  1 means write
- dmem_addr  out  32  word address {addr[31:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables, bit i = byte lane i (little-endian, lane 0 = bits 7:0)
- dmem_ack  in  1  one-cycle completion pulse; dmem_rdata is valid with it for reads
- dmem_rdata  in  32  read word

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- Define acc = mem_read_in | mem_write_in.
- An access is legal when acc is 1, read and write are not both 1, and it is aligned: half requires addr[0]=0, word requires addr[1:0]=00, byte is always aligned.
- IDLE, legal access:
  - Latch we, size, unsigned, addr[1:0] and formatted wdata/be.
  - Go to BUSY; dmem_req goes 1 from the next cycle.
- IDLE, illegal access:
  - err_out=1 combinationally.
  - No request, no stall, state stays IDLE.
- IDLE, no access: nothing happens; load_data_out holds its value.
- BUSY:
  - dmem_req=1; dmem_we/addr/wdata/be are held stable.
  - On dmem_ack: if the access is a read, format dmem_rdata into load_data_out. Clear dmem_req and go to DONE.
  - Without ack, stay in BUSY indefinitely.
- DONE: inputs are ignored, because they still carry the same instruction. Go to IDLE unconditionally.
- Store formatting:
  - SB: wdata = byte replicated into all 4 lanes; be = 1<<addr[1:0].
  - SH: wdata = half replicated into both halves; be = 0011 if addr[1]=0, else 1100.
  - SW: wdata = store_data_in; be = 1111.
- Load formatting:
  - Byte: select lane addr[1:0]. Half: select half addr[1].
  - Extend per mem_unsigned_in. Word: no change.
- Stores do not modify load_data_out.

## Timing
- stall_out = (IDLE & legal acc) | BUSY, combinational. It is 0 in DONE.
- Minimum latency:
  - Request seen at cycle T, dmem_req high at T+1, ack at T+1, DONE at T+2.
  - stall_out is high for cycles T and T+1.
  - load_data_out is valid in T+2, and MEM/WB captures it at the end of T+2.
- Each extra cycle without ack adds one stall cycle.
- Reset values: load_data_out=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_be=0, err_out=0, stall_out=0.
- rst during BUSY: IDLE at the next edge and dmem_req drops. An ack arriving later is ignored.
- An ack in IDLE or DONE is ignored with no state change.
- Back-to-back accesses: the second access is evaluated in the IDLE cycle after DONE, so there is no lost or duplicated request.

## Test plan
- LB at address 0x102, dmem_rdata=0x8899AABB, ack on the first BUSY cycle → dmem_addr=0x100, load_data_out=0xFFFFFF99 in DONE, exactly 2 stall cycles.
- LHU at address 0x102 with rdata 0x8899AABB → 0x00008899. LH at the same address → 0xFFFF8899. LW at address 0x100 → 0x8899AABB.
- SB at address 0x203 with store_data 0x000000C3, ack after 3 wait cycles → dmem_we=1, be=1000, wdata=0xC3C3C3C3, stall for 5 cycles, load_data_out unchanged.
- LW at address 0x101, then SH at address 0x001 → err_out=1 in the same cycle, no dmem_req, stall_out=0. Read and write both set → err_out=1.
- rst asserted in the second BUSY cycle, then a stray ack → dmem_req=0 after the edge, state IDLE, all outputs at reset values, ack ignored.
- Back-to-back LW then SW, each acked immediately → exactly two requests, each DONE cycle has stall_out=0, no re-issue of the first access.
